// File: rtl/food_eat_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : food_eat_ctrl_pkg
// Brief    : Shared snake-game constants, game-state encoding and the
//            coordinate distance helper.
// Revision : 1.0 - initial release
// ============================================================================
package food_eat_ctrl_pkg;

   localparam int COORD_W      = 10;
   localparam int DIFF_W       = COORD_W + 1;
   localparam int SCORE_DIGITS = 4;
   localparam int SCORE_W      = 4 * SCORE_DIGITS;

   localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

   // Game-step sequencer states; explicit 2-bit encoding shared by all
   // snake control blocks.
   typedef enum logic [1:0] {
      ST_ARMED  = 2'd0,
      ST_CHECK  = 2'd1,
      ST_DRIVE  = 2'd2,
      ST_SETTLE = 2'd3
   } game_state_t;

   // |a - b| computed as an 11-bit signed difference, so coordinate
   // extremes never wrap (0 vs 1023 gives 1023).
   function automatic logic [DIFF_W-1:0] abs_diff(
      input logic [COORD_W-1:0] a,
      input logic [COORD_W-1:0] b
   );
      logic [DIFF_W-1:0] d;
      d = {1'b0, a} - {1'b0, b};
      return d[DIFF_W-1] ? (~d + DIFF_W'(1)) : d;
   endfunction

endpackage : food_eat_ctrl_pkg
`default_nettype wire

// File: rtl/food_eat_ctrl_bcd_inc4.sv
`default_nettype none
// ============================================================================
// Module   : bcd_inc4
// Brief    : Combinational 4-digit BCD incrementer with per-digit carry,
//            saturating at 9999.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_inc4
   import food_eat_ctrl_pkg::*;
(
   input  logic [SCORE_W-1:0] score_i,
   output logic [SCORE_W-1:0] score_o
);

   logic [SCORE_DIGITS:0] w_carry;
   logic [SCORE_W-1:0]    w_inc;

   assign w_carry[0] = 1'b1;

   // Ripple the +1 through the digits: a 9 receiving a carry rolls to 0
   // and passes the carry upward.
   generate
      for (genvar d = 0; d < SCORE_DIGITS; d++) begin : g_digit
         logic [3:0] w_dig;
         logic       w_is_max;
         assign w_dig          = score_i[4*d +: 4];
         assign w_is_max       = (w_dig == BCD_DIGIT_MAX);
         assign w_carry[d+1]   = w_carry[d] & w_is_max;
         assign w_inc[4*d +: 4] = !w_carry[d] ? w_dig :
                                  (w_is_max ? 4'd0 : w_dig + 4'd1);
      end
   endgenerate

   // A carry out of the top digit only happens at 9999; hold it there.
   assign score_o = w_carry[SCORE_DIGITS] ? score_i : w_inc;

endmodule : bcd_inc4
`default_nettype wire

// File: rtl/food_eat_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : food_eat_ctrl
// Brief    : Food-box eat detection. Latches the head on each game step,
//            compares it against the box, and on a hit issues a one-cycle
//            drive/grow pulse, bumps the BCD score and blanks the box while
//            the new coordinates settle.
// Revision : 1.0 - initial release
// ============================================================================
module food_eat_ctrl
   import food_eat_ctrl_pkg::*;
#(
   parameter int HIT_TOL    = 10,
   parameter int SETTLE_CYC = 3     // legal range 2..15
)(
   input  logic               I_clk,
   input  logic               I_rst_n,
   input  logic               I_tick,
   input  logic [COORD_W-1:0] I_head_x,
   input  logic [COORD_W-1:0] I_head_y,
   input  logic [COORD_W-1:0] I_box_x,
   input  logic [COORD_W-1:0] I_box_y,
   input  logic               I_game_over,
   input  logic               I_clear,
   output logic               O_drive,
   output logic               O_grow,
   output logic               O_box_valid,
   output logic [SCORE_W-1:0] O_score
);

   localparam logic [3:0]        C_SETTLE = 4'(SETTLE_CYC);
   localparam logic [DIFF_W-1:0] C_TOL    = DIFF_W'(HIT_TOL);

   game_state_t        state_q, state_d;
   logic [COORD_W-1:0] head_x_q, head_x_d;
   logic [COORD_W-1:0] head_y_q, head_y_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               drive_q, drive_d;
   logic               grow_q, grow_d;
   logic               valid_q, valid_d;
   logic [SCORE_W-1:0] score_q, score_d;

   logic [DIFF_W-1:0]  w_dx;
   logic [DIFF_W-1:0]  w_dy;
   logic               w_hit;
   logic [SCORE_W-1:0] w_score_inc;

   // Strict tolerance window on both axes; game over forces a miss.
   assign w_dx  = abs_diff(head_x_q, I_box_x);
   assign w_dy  = abs_diff(head_y_q, I_box_y);
   assign w_hit = (w_dx < C_TOL) && (w_dy < C_TOL) && !I_game_over;

   bcd_inc4 u_bcd_inc4 (
      .score_i (score_q),
      .score_o (w_score_inc)
   );

   // State and output registers; reset restores the idle, drawable box.
   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         state_q  <= ST_ARMED;
         head_x_q <= '0;
         head_y_q <= '0;
         cnt_q    <= '0;
         drive_q  <= 1'b0;
         grow_q   <= 1'b0;
         valid_q  <= 1'b1;
         score_q  <= '0;
      end else begin
         state_q  <= state_d;
         head_x_q <= head_x_d;
         head_y_q <= head_y_d;
         cnt_q    <= cnt_d;
         drive_q  <= drive_d;
         grow_q   <= grow_d;
         valid_q  <= valid_d;
         score_q  <= score_d;
      end
   end

   // Sequencer: DRIVE launches the pulse and blanks the box on its exit
   // edge; SETTLE counts down and restores validity when it hits zero.
   always_comb begin
      state_d  = state_q;
      head_x_d = head_x_q;
      head_y_d = head_y_q;
      cnt_d    = cnt_q;
      drive_d  = 1'b0;
      grow_d   = 1'b0;
      valid_d  = valid_q;
      case (state_q)
         ST_ARMED: begin
            if (I_tick) begin
               head_x_d = I_head_x;
               head_y_d = I_head_y;
               state_d  = ST_CHECK;
            end
         end
         ST_CHECK: begin
            state_d = w_hit ? ST_DRIVE : ST_ARMED;
         end
         ST_DRIVE: begin
            drive_d = 1'b1;
            grow_d  = 1'b1;
            valid_d = 1'b0;
            cnt_d   = C_SETTLE;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            valid_d = 1'b0;
            if (cnt_q == 4'd0) begin
               valid_d = 1'b1;
               state_d = ST_ARMED;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_ARMED;
            valid_d = 1'b1;
         end
      endcase
   end

   // Score: the increment lands the cycle after the drive pulse; clear wins.
   always_comb begin
      score_d = score_q;
      if (I_clear) begin
         score_d = '0;
      end else if (drive_q) begin
         score_d = w_score_inc;
      end
   end

   assign O_drive     = drive_q;
   assign O_grow      = grow_q;
   assign O_box_valid = valid_q;
   assign O_score     = score_q;

endmodule : food_eat_ctrl
`default_nettype wire

// File: tb/tb_food_eat_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_food_eat_ctrl
// Brief    : Self-checking bench for food_eat_ctrl and bcd_inc4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_food_eat_ctrl;

   localparam int HIT_TOL = 10;
   localparam int SETTLE  = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic [9:0] hx = '0, hy = '0, bx = '0, by = '0;
   logic       go = 1'b0;
   logic       clr = 1'b0;
   logic       drive, grow, valid;
   logic [15:0] score;

   logic [15:0] bcd_in = '0;
   logic [15:0] bcd_out;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   int n        = 0;

   // reference model: absolute edge schedule of the pending step
   int m_free, m_check, m_drive, m_from, m_to, m_score;
   logic [9:0] m_hx, m_hy;

   food_eat_ctrl #(.HIT_TOL(HIT_TOL), .SETTLE_CYC(SETTLE)) dut (
      .I_clk       (clk),
      .I_rst_n     (rst_n),
      .I_tick      (tick),
      .I_head_x    (hx),
      .I_head_y    (hy),
      .I_box_x     (bx),
      .I_box_y     (by),
      .I_game_over (go),
      .I_clear     (clr),
      .O_drive     (drive),
      .O_grow      (grow),
      .O_box_valid (valid),
      .O_score     (score)
   );

   bcd_inc4 u_bcd (
      .score_i (bcd_in),
      .score_o (bcd_out)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %h expected %h", name, n, act, exp);
      end
   endtask

   task automatic model_edge();
      int dx, dy;
      if (!rst_n) begin
         m_free = 0; m_check = -100; m_drive = -100; m_from = -100; m_to = -100;
         m_score = 0; m_hx = '0; m_hy = '0;
      end else begin
         if (clr) m_score = 0;
         else if (n == m_drive + 1) m_score = (m_score < 9999) ? m_score + 1 : 9999;
         if (n == m_check) begin
            dx = int'(m_hx) - int'(bx); if (dx < 0) dx = -dx;
            dy = int'(m_hy) - int'(by); if (dy < 0) dy = -dy;
            if (dx < HIT_TOL && dy < HIT_TOL && !go) begin
               m_drive = n + 1;
               m_from  = n + 1;
               m_to    = n + 2 + SETTLE;
               m_free  = n + 3 + SETTLE;
            end else begin
               m_free = n + 1;
            end
         end else if (tick && n >= m_free) begin
            m_hx = hx; m_hy = hy;
            m_check = n + 1;
            m_free  = 1 << 30;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      n++;
      model_edge();
      #1;
      check("drive", 16'(drive), 16'(n == m_drive));
      check("grow",  16'(grow),  16'(n == m_drive));
      check("valid", 16'(valid), 16'(!(n >= m_from && n < m_to)));
      check("score", score, to_bcd(m_score));
      if (drive) pulses++;
   endtask

   typedef struct {
      logic [15:0] in;
      logic [15:0] exp;
   } bcd_vec_t;

   typedef struct {
      logic [9:0] hx, hy, bx, by;
      logic       go;
      int         exp_hit;
   } hit_vec_t;

   bcd_vec_t bvec[8];
   hit_vec_t hvec[10];

   initial begin
      bvec[0] = '{16'h0000, 16'h0001};
      bvec[1] = '{16'h0009, 16'h0010};
      bvec[2] = '{16'h0099, 16'h0100};
      bvec[3] = '{16'h0999, 16'h1000};
      bvec[4] = '{16'h9999, 16'h9999};
      bvec[5] = '{16'h1234, 16'h1235};
      bvec[6] = '{16'h8999, 16'h9000};
      bvec[7] = '{16'h9998, 16'h9999};

      hvec[0] = '{10'd345, 10'd330, 10'd340, 10'd332, 1'b0, 1};
      hvec[1] = '{10'd350, 10'd332, 10'd340, 10'd332, 1'b0, 0};
      hvec[2] = '{10'd349, 10'd341, 10'd340, 10'd332, 1'b0, 1};
      hvec[3] = '{10'd330, 10'd332, 10'd340, 10'd332, 1'b0, 0};
      hvec[4] = '{10'd331, 10'd323, 10'd340, 10'd332, 1'b0, 1};
      hvec[5] = '{10'd0,   10'd0,   10'd1023, 10'd0,  1'b0, 0};
      hvec[6] = '{10'd1023, 10'd5,  10'd0,   10'd5,   1'b0, 0};
      hvec[7] = '{10'd340, 10'd332, 10'd340, 10'd332, 1'b1, 0};
      hvec[8] = '{10'd340, 10'd332, 10'd340, 10'd332, 1'b0, 1};
      hvec[9] = '{10'd340, 10'd341, 10'd340, 10'd332, 1'b0, 1};

      // incrementer carry and saturation table
      for (int i = 0; i < 8; i++) begin
         bcd_in = bvec[i].in;
         #1;
         check("bcd_inc", bcd_out, bvec[i].exp);
      end

      // reset, then idle
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      pulses = 0;
      repeat (20) step();
      check("idle_pulses", 16'(pulses), 16'd0);
      check("idle_valid", 16'(valid), 16'd1);

      // hit/miss table, one game step each
      for (int i = 0; i < 10; i++) begin
         hx = hvec[i].hx; hy = hvec[i].hy;
         bx = hvec[i].bx; by = hvec[i].by;
         go = hvec[i].go;
         pulses = 0;
         tick = 1'b1; step(); tick = 1'b0;
         repeat (9) step();
         check("hit_vec", 16'(pulses), 16'(hvec[i].exp_hit));
         go = 1'b0;
      end

      // clear, then 11 hits to cross the 0009->0010 carry in the top
      clr = 1'b1; step(); clr = 1'b0;
      hx = 10'd345; hy = 10'd330; bx = 10'd340; by = 10'd332;
      for (int i = 0; i < 11; i++) begin
         tick = 1'b1; step(); tick = 1'b0;
         repeat (7) step();
      end
      check("score_11", score, 16'h0011);

      // extra ticks during CHECK/DRIVE ignored; clear beats the increment
      pulses = 0;
      tick = 1'b1; step(); step(); step();
      tick = 1'b0; clr = 1'b1; step(); clr = 1'b0;
      repeat (8) step();
      check("single_drive", 16'(pulses), 16'd1);
      check("clear_prio", score, 16'h0000);

      // reset in the middle of SETTLE
      tick = 1'b1; step(); tick = 1'b0;
      step(); step(); step();
      check("in_settle_valid", 16'(valid), 16'd0);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      check("rst_valid", 16'(valid), 16'd1);
      check("rst_drive", 16'(drive), 16'd0);
      check("rst_score", score, 16'h0000);
      pulses = 0;
      tick = 1'b1; step(); tick = 1'b0;
      repeat (9) step();
      check("post_rst_hit", 16'(pulses), 16'd1);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int off, v;
         bx = 10'($urandom_range(0, 1023));
         by = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) == 0) begin
            hx = 10'($urandom_range(0, 1023));
            hy = 10'($urandom_range(0, 1023));
         end else begin
            off = int'($urandom_range(0, 30)) - 15;
            v = int'(bx) + off; if (v < 0) v = 0; if (v > 1023) v = 1023;
            hx = 10'(v);
            off = int'($urandom_range(0, 30)) - 15;
            v = int'(by) + off; if (v < 0) v = 0; if (v > 1023) v = 1023;
            hy = 10'(v);
         end
         tick  = ($urandom_range(0, 2) == 0);
         go    = ($urandom_range(0, 9) == 0);
         clr   = ($urandom_range(0, 59) == 0);
         rst_n = ($urandom_range(0, 499) != 0);
         step();
      end
      tick = 1'b0; go = 1'b0; clr = 1'b0; rst_n = 1'b1;
      repeat (10) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_food_eat_ctrl
`default_nettype wire
